// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ALU controller (master) and the execute unit (slave).
// start/alu_op/operands flow controller->unit; busy/done/alu_result/zero flow back.
interface alu_exec_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_operand1;
    logic [DATA_WIDTH-1:0] alu_operand2;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  zero;

    modport master (
        output start, alu_op, alu_operand1, alu_operand2,
        input  busy, done, alu_result, zero
    );

    modport slave (
        input  start, alu_op, alu_operand1, alu_operand2,
        output busy, done, alu_result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execute unit: one-cycle arithmetic/logic ops, bit-serial shifts.
// Handshake: start is taken on a rising edge only in IDLE or DONE; done pulses one cycle when results update.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_exec_unit_if.slave bus,
    output logic [1:0]   state_dbg
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state;
    logic [4:0]            cnt;
    logic [3:0]            op_q;
    logic                  fill_q;
    logic [DATA_WIDTH-1:0] work;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;

    logic                  accept;
    logic                  acc_is_shift;
    logic                  acc_multi;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] acc_value;
    logic [DATA_WIDTH-1:0] acc_first;
    logic [DATA_WIDTH-1:0] shifted;

    function automatic logic [DATA_WIDTH-1:0] shift_one(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] v,
        input logic                  fill
    );
        case (op)
            ALU_SLL: shift_one = {v[DATA_WIDTH-2:0], 1'b0};
            ALU_SRL: shift_one = {1'b0, v[DATA_WIDTH-1:1]};
            default: shift_one = {fill, v[DATA_WIDTH-1:1]};
        endcase
    endfunction

    assign shamt        = bus.alu_operand2[4:0];
    assign accept       = bus.start && (state == IDLE || state == DONE);
    assign acc_is_shift = (bus.alu_op == ALU_SLL) || (bus.alu_op == ALU_SRL) ||
                          (bus.alu_op == ALU_SRA);
    // The accept edge performs the first bit of a shift, so a k-bit shift completes in k edges.
    assign acc_multi    = acc_is_shift && (shamt > 5'd1);
    assign acc_first    = shift_one(bus.alu_op, bus.alu_operand1, bus.alu_operand1[DATA_WIDTH-1]);
    assign shifted      = shift_one(op_q, work, fill_q);

    always_comb begin
        acc_value = bus.alu_operand1 + bus.alu_operand2;
        case (bus.alu_op)
            ALU_SUB:  acc_value = bus.alu_operand1 - bus.alu_operand2;
            ALU_AND:  acc_value = bus.alu_operand1 & bus.alu_operand2;
            ALU_OR:   acc_value = bus.alu_operand1 | bus.alu_operand2;
            ALU_XOR:  acc_value = bus.alu_operand1 ^ bus.alu_operand2;
            ALU_SLL, ALU_SRL, ALU_SRA:
                acc_value = (shamt == 5'd0) ? bus.alu_operand1 : acc_first;
            ALU_SLT:  acc_value = {{(DATA_WIDTH-1){1'b0}},
                                   ($signed(bus.alu_operand1) < $signed(bus.alu_operand2))};
            ALU_SLTU: acc_value = {{(DATA_WIDTH-1){1'b0}},
                                   (bus.alu_operand1 < bus.alu_operand2)};
            default:  acc_value = bus.alu_operand1 + bus.alu_operand2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            fill_q   <= 1'b0;
            work     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q   <= bus.alu_op;
                        fill_q <= bus.alu_operand1[DATA_WIDTH-1];
                        work   <= acc_first;
                        if (acc_multi) begin
                            cnt   <= shamt - 5'd1;
                            state <= SHIFT;
                        end else begin
                            cnt      <= '0;
                            result_q <= acc_value;
                            zero_q   <= (acc_value == '0);
                            state    <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result_q <= shifted;
                        zero_q   <= (shifted == '0);
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == SHIFT);
    assign bus.done       = (state == DONE);
    assign bus.alu_result = result_q;
    assign bus.zero       = zero_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus hand-written multi-cycle sequences.
module tb_alu_exec_unit;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         n_tests;
    int         n_fail;
    vec_t       vecs[16];

    alu_exec_unit_if #(.DATA_WIDTH(32)) bus ();

    alu_exec_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller guarantees time is away from a rising edge when this is entered.
    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input int exp_lat, input bit hold);
        logic [31:0] prev;
        int          lat;
        int          busy_cnt;
        logic        held;
        prev             = bus.alu_result;
        bus.alu_op       = op;
        bus.alu_operand1 = a;
        bus.alu_operand2 = b;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        held     = 1'b1;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.alu_result !== prev) held = 1'b0;
            if (hold) begin
                bus.alu_op       = 4'($urandom_range(0, 15));
                bus.alu_operand1 = $urandom;
                bus.alu_operand2 = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check({name, " done_seen"}, {31'd0, bus.done}, 32'd1);
        check({name, " result"}, bus.alu_result, res);
        check({name, " zero"}, {31'd0, bus.zero}, {31'd0, z});
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy_cycles"}, busy_cnt, (exp_lat > 1) ? exp_lat - 1 : 0);
        if (exp_lat > 1) check({name, " result_held"}, {31'd0, held}, 32'd1);
        @(posedge clk); #1;
        check({name, " done_pulse_end"}, {31'd0, bus.done}, 32'd0);
        check({name, " busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.alu_op       = ALU_ADD;
        bus.alu_operand1 = '0;
        bus.alu_operand2 = '0;

        vecs[0]  = '{"add_wrap",   ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1};
        vecs[1]  = '{"sub_neg",    ALU_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1};
        vecs[2]  = '{"slt_neg",    ALU_SLT,  32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 1};
        vecs[3]  = '{"sltu_big",   ALU_SLTU, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b1, 1};
        vecs[4]  = '{"and",        ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1};
        vecs[5]  = '{"or",         ALU_OR,   32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1};
        vecs[6]  = '{"xor",        ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1};
        vecs[7]  = '{"sra_3",      ALU_SRA,  32'h80000000, 32'h00000023, 32'hF0000000, 1'b0, 3};
        vecs[8]  = '{"sll_0",      ALU_SLL,  32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1};
        vecs[9]  = '{"srl_4",      ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 4};
        vecs[10] = '{"sra_1_pos",  ALU_SRA,  32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 1'b0, 1};
        vecs[11] = '{"bad_op_add", 4'hF,     32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1};
        vecs[12] = '{"slt_false",  ALU_SLT,  32'h00000001, 32'hFFFFFFFE, 32'h00000000, 1'b1, 1};
        vecs[13] = '{"sub_zero",   ALU_SUB,  32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1};
        vecs[14] = '{"sll_2_mask", ALU_SLL,  32'h00000001, 32'hFFFFFFE2, 32'h00000004, 1'b0, 2};
        vecs[15] = '{"sltu_true",  ALU_SLTU, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1};

        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.alu_result, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd1);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z,
                  vecs[i].lat, 1'b0);
        end

        // Start held high with churning operands through a 31-bit shift.
        do_op("sll_31_held", ALU_SLL, 32'h00000001, 32'd31, 32'h80000000, 1'b0, 31, 1'b1);

        // Back-to-back ADD then AND, start high in the DONE cycle.
        bus.alu_op       = ALU_ADD;
        bus.alu_operand1 = 32'd10;
        bus.alu_operand2 = 32'd20;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        check("b2b_done1", {31'd0, bus.done}, 32'd1);
        check("b2b_res1", bus.alu_result, 32'd30);
        bus.alu_op       = ALU_AND;
        bus.alu_operand1 = 32'hFF00FF00;
        bus.alu_operand2 = 32'h0F0F0F0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_done2", {31'd0, bus.done}, 32'd1);
        check("b2b_res2", bus.alu_result, 32'h0F000F00);
        check("b2b_zero2", {31'd0, bus.zero}, 32'd0);
        @(posedge clk); #1;
        check("b2b_done_end", {31'd0, bus.done}, 32'd0);

        // Reset asserted ten cycles into a 31-bit SRL.
        bus.alu_op       = ALU_SRL;
        bus.alu_operand1 = 32'h80000000;
        bus.alu_operand2 = 32'd31;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        check("mid_result_held", bus.alu_result, 32'h0F000F00);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_result", bus.alu_result, 32'd0);
        check("mid_rst_zero", {31'd0, bus.zero}, 32'd1);
        check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_done", {31'd0, bus.done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op("add_after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
